// File: rtl/dds_pkg.sv
// Shared types and constants for the DDS waveform generator.
// Sine table holds one quarter wave, entry k = round(2047*sin((k+0.5)*pi/128)).
package dds_pkg;

   typedef enum logic [1:0] {
      WAVE_SAW = 2'd0,
      WAVE_TRI = 2'd1,
      WAVE_SQR = 2'd2,
      WAVE_SIN = 2'd3
   } wave_sel_t;

   localparam int DDS_M_DEF        = 12;
   localparam int DDS_PHASE_W_DEF  = 16;
   localparam int DDS_PWM_BITS_DEF = 4;

   localparam int SINE_M       = 12;
   localparam int SINE_ENTRIES = 64;
   localparam int SINE_MAG_W   = 11;

   localparam logic [SINE_MAG_W-1:0] SINE_QTR [SINE_ENTRIES] = '{
      11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
      11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
      11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
      11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
      11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
      11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
      11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
      11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
   };

endpackage

// File: rtl/dds_sine_lut.sv
// Quarter-wave sine lookup with mirror/negate into a 12-bit offset-binary sample.
// Latency: combinational, no registers.
// Backpressure: none, pure function of the phase input.
module dds_sine_lut
   import dds_pkg::*;
(
   input  logic [SINE_M-1:0] phase,
   output logic [SINE_M-1:0] sample
);

   logic [5:0]            idx;
   logic [SINE_MAG_W-1:0] mag;

   // Second and fourth quarters run the table backwards.
   always_comb begin
      idx    = phase[10] ? ~phase[9:4] : phase[9:4];
      mag    = SINE_QTR[idx];
      sample = phase[11] ? (12'h7FF - {1'b0, mag}) : (12'h800 + {1'b0, mag});
   end

endmodule

// File: rtl/dds_wavegen.sv
// DDS front end for the pwm stage: phase accumulator stepped once per PWM period, shaper, output register.
// Latency: modu/sample_stb update one cycle after a terminal-count or phase_rst cycle; build option DDS_SINE_EN adds the sine LUT.
// Backpressure: one-deep tuning-word buffer, ftw_ready drops while a word waits for the next period boundary.
module dds_wavegen
   import dds_pkg::*;
#(
   parameter int M        = DDS_M_DEF,
   parameter int PHASE_W  = DDS_PHASE_W_DEF,
   parameter int PWM_BITS = DDS_PWM_BITS_DEF
)(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PHASE_W-1:0] ftw_data,
   input  logic               ftw_valid,
   output logic               ftw_ready,
   input  logic [1:0]         wave_sel,
   input  logic               phase_rst,
   output logic [M-1:0]       modu,
   output logic               sample_stb
);

   if (M < 8 || M > 16 || PHASE_W < M) begin : g_bad_param
      $error("dds_wavegen: M must be 8..16 and PHASE_W >= M");
   end

   logic [PWM_BITS-1:0] cnt;
   logic [PHASE_W-1:0]  phase;
   logic [PHASE_W-1:0]  ftw_act;
   logic [PHASE_W-1:0]  ftw_pend;
   logic                pend_v;

   logic                tc;
   logic                upd;
   logic [PHASE_W-1:0]  phase_nxt;
   logic [M-1:0]        p;
   logic [M-1:0]        tri_base;
   logic [M-1:0]        tri_val;
   logic [M-1:0]        sqr_val;
   logic [M-1:0]        sine_val;
   logic [M-1:0]        shaped;

`ifdef DDS_SINE_EN
   if (M != SINE_M) begin : g_bad_sine_m
      $error("dds_wavegen: DDS_SINE_EN requires M == 12");
   end

   dds_sine_lut u_sine (
      .phase  (p),
      .sample (sine_val)
   );
`else
   assign sine_val = tri_val;
`endif

   // The shaper sees the phase that will be in effect after this edge, so
   // modu and phase move together and pwm never gets a stale sample.
   always_comb begin
      tc  = &cnt;
      upd = tc | phase_rst;

      phase_nxt = phase;
      if (phase_rst) begin
         phase_nxt = '0;
      end else if (tc) begin
         phase_nxt = phase + ftw_act;
      end

      p        = phase_nxt[PHASE_W-1 -: M];
      tri_base = {p[M-2:0], 1'b0};
      tri_val  = p[M-1] ? ~tri_base : tri_base;
      sqr_val  = p[M-1] ? '0 : '1;

      shaped = p;
      case (wave_sel_t'(wave_sel))
         WAVE_SAW: shaped = p;
         WAVE_TRI: shaped = tri_val;
         WAVE_SQR: shaped = sqr_val;
         WAVE_SIN: shaped = sine_val;
         default:  shaped = p;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         phase      <= '0;
         ftw_act    <= '0;
         ftw_pend   <= '0;
         pend_v     <= 1'b0;
         modu       <= '0;
         sample_stb <= 1'b0;
      end else begin
         cnt   <= phase_rst ? '0 : cnt + 1'b1;
         phase <= phase_nxt;

         // Only a word already pending before this TC is promoted.
         if (tc && pend_v) begin
            ftw_act <= ftw_pend;
            pend_v  <= 1'b0;
         end else if (ftw_valid && !pend_v) begin
            ftw_pend <= ftw_data;
            pend_v   <= 1'b1;
         end

         sample_stb <= upd;
         if (upd) begin
            modu <= shaped;
         end
      end
   end

   assign ftw_ready = !pend_v;

endmodule

// File: tb/tb_dds_wavegen.sv
// Scoreboard bench for dds_wavegen at default parameters; sine vectors selected by DDS_SINE_EN.
module tb_dds_wavegen;

   localparam int M        = 12;
   localparam int PHASE_W  = 16;
   localparam int PWM_BITS = 4;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PHASE_W-1:0] ftw_data;
   logic               ftw_valid;
   logic               ftw_ready;
   logic [1:0]         wave_sel;
   logic               phase_rst;
   logic [M-1:0]       modu;
   logic               sample_stb;

   always #5 clk = ~clk;

   dds_wavegen #(
      .M        (M),
      .PHASE_W  (PHASE_W),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ftw_data   (ftw_data),
      .ftw_valid  (ftw_valid),
      .ftw_ready  (ftw_ready),
      .wave_sel   (wave_sel),
      .phase_rst  (phase_rst),
      .modu       (modu),
      .sample_stb (sample_stb)
   );

   typedef struct {
      logic [M-1:0] val;
      int           gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   pos   = 0;
   int   gap   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic push_exp(input logic [M-1:0] v, input int g);
      exp_t e;
      e.val = v;
      e.gap = g;
      sb.push_back(e);
   endtask

   // Leaves us at the negedge before clock edge e (edges counted from reset release).
   task automatic go_to(input int e);
      while (pos < e) begin
         @(negedge clk);
         pos++;
      end
   endtask

   task automatic release_rst();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      pos   = 0;
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (!rst_n) begin
         gap = 0;
      end else begin
         gap++;
         if (sample_stb === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: modu=0x%0h with no sample expected", modu);
            end else begin
               e = sb.pop_front();
               chk("modu", 32'(modu), 32'(e.val));
               chk("strobe_gap", gap, e.gap);
            end
            gap = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, total=%0d", total);
      $fatal(1);
   end

   logic [M-1:0] tri_exp [9];
   logic [M-1:0] wave3_exp [5];

   initial begin
      rst_n     = 1'b0;
      ftw_data  = '0;
      ftw_valid = 1'b0;
      wave_sel  = 2'd0;
      phase_rst = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_modu", 32'(modu), 32'h0);
      chk("rst_ready", 32'(ftw_ready), 32'h1);
      chk("rst_stb", 32'(sample_stb), 32'h0);

      // Idle with ftw=0: saw stays at 0, square at phase 0 is full scale.
      release_rst();
      push_exp(12'h000, 16);
      push_exp(12'h000, 16);
      push_exp(12'hFFF, 16);
      go_to(40);
      wave_sel = 2'd2;

      // Saw, ftw 0x1000.
      go_to(49);
      chk("ready_e49", 32'(ftw_ready), 32'h1);
      wave_sel  = 2'd0;
      ftw_data  = 16'h1000;
      ftw_valid = 1'b1;
      push_exp(12'h000, 16);
      for (int j = 1; j <= 15; j++) push_exp(12'(j << 8), 16);
      push_exp(12'h000, 16);
      push_exp(12'h100, 16);
      go_to(50);
      ftw_valid = 1'b0;
      chk("ready_pend_e50", 32'(ftw_ready), 32'h0);
      go_to(64);
      chk("ready_pend_e64", 32'(ftw_ready), 32'h0);
      go_to(65);
      chk("ready_free_e65", 32'(ftw_ready), 32'h1);

      // Triangle, ftw 0x2000; phase is 0x1000 so the first step lands on 0x2000.
      tri_exp = '{12'h400, 12'h800, 12'hC00, 12'hFFF, 12'hBFF, 12'h7FF, 12'h3FF, 12'h000, 12'h400};
      go_to(337);
      wave_sel  = 2'd1;
      ftw_data  = 16'h2000;
      ftw_valid = 1'b1;
      foreach (tri_exp[i]) push_exp(tri_exp[i], 16);
      go_to(338);
      ftw_valid = 1'b0;

      // Two words offered back to back with ftw_valid held.
      go_to(481);
      wave_sel  = 2'd0;
      ftw_data  = 16'h0100;
      ftw_valid = 1'b1;
      push_exp(12'h400, 16);
      push_exp(12'h410, 16);
      push_exp(12'h440, 16);
      push_exp(12'h470, 16);
      push_exp(12'h4A0, 16);
      push_exp(12'h520, 16);
      go_to(482);
      ftw_data = 16'h0300;
      chk("ready_hold_e482", 32'(ftw_ready), 32'h0);
      go_to(496);
      chk("ready_hold_e496", 32'(ftw_ready), 32'h0);
      go_to(497);
      chk("ready_second_e497", 32'(ftw_ready), 32'h1);
      go_to(498);
      ftw_valid = 1'b0;
      chk("ready_second_e498", 32'(ftw_ready), 32'h0);

      // Word offered on a TC edge waits a full period.
      go_to(544);
      ftw_data  = 16'h0800;
      ftw_valid = 1'b1;
      go_to(545);
      ftw_valid = 1'b0;
      chk("ready_tc_e545", 32'(ftw_ready), 32'h0);
      go_to(560);
      chk("ready_tc_e560", 32'(ftw_ready), 32'h0);
      go_to(561);
      chk("ready_tc_e561", 32'(ftw_ready), 32'h1);

      // phase_rst while cnt == 7.
      go_to(584);
      phase_rst = 1'b1;
      push_exp(12'h000, 8);
      push_exp(12'h080, 16);
      push_exp(12'h100, 16);
      go_to(585);
      phase_rst = 1'b0;

      // rst_n with a word pending: pending word and active word are both lost.
      go_to(620);
      ftw_data  = 16'h1234;
      ftw_valid = 1'b1;
      go_to(621);
      ftw_valid = 1'b0;
      chk("ready_pend_e621", 32'(ftw_ready), 32'h0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(ftw_ready), 32'h1);
      chk("midrst_modu", 32'(modu), 32'h0);
      chk("midrst_stb", 32'(sample_stb), 32'h0);
      release_rst();
      push_exp(12'h000, 16);
      push_exp(12'h000, 16);

      // wave_sel 3 with ftw 0x4000 starting from phase 0.
`ifdef DDS_SINE_EN
      wave3_exp = '{12'h819, 12'hFFF, 12'h7E6, 12'h000, 12'h819};
`else
      wave3_exp = '{12'h000, 12'h800, 12'hFFF, 12'h7FF, 12'h000};
`endif
      go_to(33);
      chk("ready_after_rst", 32'(ftw_ready), 32'h1);
      wave_sel  = 2'd3;
      ftw_data  = 16'h4000;
      ftw_valid = 1'b1;
      foreach (wave3_exp[i]) push_exp(wave3_exp[i], 16);
      go_to(34);
      ftw_valid = 1'b0;

      go_to(120);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
